// File: rtl/csr_timer_if.sv
// rtl/csr_timer_if.sv - CSR access bus shared by the CSR file and the constant timer
interface csr_timer_if;
    logic        csr_we;
    logic [11:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;

    modport master (
        output csr_we,
        output csr_num,
        output csr_wmask,
        output csr_wdata,
        input  csr_rdata,
        input  csr_hit
    );

    modport slave (
        input  csr_we,
        input  csr_num,
        input  csr_wmask,
        input  csr_wdata,
        output csr_rdata,
        output csr_hit
    );
endinterface

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - constant timer CSRs (TID/TCFG/TVAL/TICLR), down-counter and timer interrupt
module csr_timer #(
    parameter int          TIMER_W = 32,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic       clk,
    input  logic       reset,
    csr_timer_if.slave csr,
    output logic       timer_int
);
    localparam logic [11:0] ADDR_TID   = 12'h040;
    localparam logic [11:0] ADDR_TCFG  = 12'h041;
    localparam logic [11:0] ADDR_TVAL  = 12'h042;
    localparam logic [11:0] ADDR_TICLR = 12'h044;

    localparam logic [TIMER_W-1:0] ALL_ONES = '1;
    localparam logic [TIMER_W-1:0] ONE      = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        tid;
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] tval;

    logic               we_tid;
    logic               we_tcfg;
    logic               ti_clr;
    logic               ti_set;
    logic [TIMER_W-1:0] wmask_w;
    logic [TIMER_W-1:0] wdata_w;
    logic [TIMER_W-1:0] tcfg_new;
    logic [TIMER_W-1:0] reload_new;
    logic [TIMER_W-1:0] reload_cur;

    assign we_tid  = csr.csr_we && (csr.csr_num == ADDR_TID);
    assign we_tcfg = csr.csr_we && (csr.csr_num == ADDR_TCFG);
    assign ti_clr  = csr.csr_we && (csr.csr_num == ADDR_TICLR)
                     && csr.csr_wmask[0] && csr.csr_wdata[0];

    assign wmask_w    = csr.csr_wmask[TIMER_W-1:0];
    assign wdata_w    = csr.csr_wdata[TIMER_W-1:0];
    assign tcfg_new   = (tcfg & ~wmask_w) | (wdata_w & wmask_w);
    assign reload_new = {tcfg_new[TIMER_W-1:2], 2'b00};
    assign reload_cur = {tcfg[TIMER_W-1:2], 2'b00};

    // A TCFG write suppresses expiry in its cycle; expiry beats a same-edge TICLR clear.
    assign ti_set = !we_tcfg && (state == S_COUNT) && (tval == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tid       <= TID_RST;
            tcfg      <= '0;
            tval      <= ALL_ONES;
            timer_int <= 1'b0;
        end else begin
            if (we_tid) begin
                tid <= (tid & ~csr.csr_wmask) | (csr.csr_wdata & csr.csr_wmask);
            end
            timer_int <= ti_set | (timer_int & ~ti_clr);

            if (we_tcfg) begin
                tcfg <= tcfg_new;
                if (tcfg_new[0]) begin
                    tval  <= reload_new;
                    state <= S_COUNT;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                case (state)
                    S_COUNT: begin
                        if (tval != '0) begin
                            tval <= tval - ONE;
                        end else if (tcfg[1]) begin
                            tval <= reload_cur;
                        end else begin
                            tval  <= ALL_ONES;
                            state <= S_EXPIRED;
                        end
                    end
                    S_EXPIRED: state <= S_EXPIRED;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        csr.csr_rdata = 32'h0;
        csr.csr_hit   = 1'b0;
        case (csr.csr_num)
            ADDR_TID: begin
                csr.csr_rdata = tid;
                csr.csr_hit   = 1'b1;
            end
            ADDR_TCFG: begin
                csr.csr_rdata = 32'(tcfg);
                csr.csr_hit   = 1'b1;
            end
            ADDR_TVAL: begin
                csr.csr_rdata = 32'(tval);
                csr.csr_hit   = 1'b1;
            end
            ADDR_TICLR: begin
                csr.csr_hit   = 1'b1;
            end
            default: begin
                csr.csr_rdata = 32'h0;
                csr.csr_hit   = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_csr_timer.sv
// tb/tb_csr_timer.sv - self-checking bench for csr_timer
module tb_csr_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic timer_int;

    csr_timer_if bus();

    csr_timer #(.TIMER_W(32), .TID_RST(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .csr       (bus),
        .timer_int (timer_int)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: "running" means a countdown is in progress; idle and expired look alike from outside.
    logic [31:0] m_tid;
    logic [31:0] m_tcfg;
    logic [31:0] m_tval;
    bit          m_run;
    bit          m_ti;

    typedef struct {
        bit          we;
        logic [11:0] num;
        logic [31:0] mask;
        logic [31:0] data;
        logic [11:0] rd_num;
        logic [31:0] exp_rd;
        bit          exp_hit;
        bit          exp_int;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tid  = 32'h0;
        m_tcfg = 32'h0;
        m_tval = 32'hFFFF_FFFF;
        m_run  = 1'b0;
        m_ti   = 1'b0;
    endtask

    task automatic model_edge(input bit we, input logic [11:0] num,
                              input logic [31:0] mask, input logic [31:0] data);
        bit set_ti;
        bit clr_ti;
        set_ti = 1'b0;
        clr_ti = 1'b0;
        if (we && num == 12'h040) m_tid = (m_tid & ~mask) | (data & mask);
        if (we && num == 12'h044 && mask[0] && data[0]) clr_ti = 1'b1;
        if (we && num == 12'h041) begin
            m_tcfg = (m_tcfg & ~mask) | (data & mask);
            m_run  = m_tcfg[0];
            if (m_run) m_tval = (m_tcfg >> 2) * 4;
        end else if (m_run) begin
            if (m_tval > 0) begin
                m_tval = m_tval - 1;
            end else begin
                set_ti = 1'b1;
                if (m_tcfg[1]) begin
                    m_tval = (m_tcfg >> 2) * 4;
                end else begin
                    m_tval = 32'hFFFF_FFFF;
                    m_run  = 1'b0;
                end
            end
        end
        m_ti = set_ti || (m_ti && !clr_ti);
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] num);
        case (num)
            12'h040: return m_tid;
            12'h041: return m_tcfg;
            12'h042: return m_tval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_hit(input logic [11:0] num);
        return (num == 12'h040) || (num == 12'h041) || (num == 12'h042) || (num == 12'h044);
    endfunction

    task automatic cyc(input bit we, input logic [11:0] num,
                       input logic [31:0] mask, input logic [31:0] data);
        bus.csr_we    = we;
        bus.csr_num   = num;
        bus.csr_wmask = mask;
        bus.csr_wdata = data;
        @(posedge clk);
        model_edge(we, num, mask, data);
        #1;
        bus.csr_we = 1'b0;
        chk("int_vs_model", {31'b0, timer_int}, {31'b0, m_ti});
    endtask

    task automatic rst_cyc();
        bus.csr_we = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 12'h000, 32'h0, 32'h0);
    endtask

    task automatic rd(input string name, input logic [11:0] num, input logic [31:0] exp);
        bus.csr_num = num;
        #1;
        chk(name, bus.csr_rdata, exp);
    endtask

    task automatic chk_int(input string name, input bit exp);
        chk(name, {31'b0, timer_int}, {31'b0, exp});
    endtask

    task automatic wr_tcfg(input logic [31:0] v);
        cyc(1'b1, 12'h041, 32'hFFFF_FFFF, v);
    endtask

    task automatic clr_ti();
        cyc(1'b1, 12'h044, 32'h1, 32'h1);
    endtask

    initial begin
        bus.csr_we    = 1'b0;
        bus.csr_num   = 12'h0;
        bus.csr_wmask = 32'h0;
        bus.csr_wdata = 32'h0;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,         32'h0,         12'h041, 32'h0,         1'b1, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 32'h0,         32'h0,         12'h042, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 12'h000, 32'h0,         32'h0,         12'h044, 32'h0,         1'b1, 1'b0};
        vecs[3]  = '{1'b0, 12'h000, 32'h0,         32'h0,         12'h005, 32'h0,         1'b0, 1'b0};
        vecs[4]  = '{1'b1, 12'h040, 32'hFFFF_FFFF, 32'h1234_5678, 12'h040, 32'h1234_5678, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 12'h040, 32'h0000_FFFF, 32'hAAAA_AAAA, 12'h040, 32'h1234_AAAA, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 12'h042, 32'hFFFF_FFFF, 32'h0,         12'h042, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 12'h041, 32'hFFFF_FFFF, 32'h0000_0010, 12'h041, 32'h0000_0010, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 12'h041, 32'hFFFF_FFFF, 32'h0000_0011, 12'h042, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 12'h044, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'h044, 32'h0,         1'b1, 1'b0};
        vecs[10] = '{1'b0, 12'h000, 32'h0,         32'h0,         12'h043, 32'h0,         1'b0, 1'b0};
        vecs[11] = '{1'b0, 12'h000, 32'h0,         32'h0,         12'h045, 32'h0,         1'b0, 1'b0};

        rst_cyc();
        chk_int("reset_int", 1'b0);

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].we, vecs[i].num, vecs[i].mask, vecs[i].data);
            bus.csr_num = vecs[i].rd_num;
            #1;
            chk($sformatf("vec%0d_rdata", i), bus.csr_rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_hit", i), {31'b0, bus.csr_hit}, {31'b0, vecs[i].exp_hit});
            chk($sformatf("vec%0d_int", i), {31'b0, timer_int}, {31'b0, vecs[i].exp_int});
        end

        // One-shot, InitVal=4
        wr_tcfg(32'h11);
        rd("os_load", 12'h042, 32'd16);
        idle(16);
        rd("os_zero", 12'h042, 32'd0);
        chk_int("os_int_before", 1'b0);
        idle(1);
        chk_int("os_int_expiry", 1'b1);
        rd("os_tval_ones", 12'h042, 32'hFFFF_FFFF);
        idle(5);
        rd("os_tval_held", 12'h042, 32'hFFFF_FFFF);
        clr_ti();
        chk_int("os_int_cleared", 1'b0);
        idle(3);
        chk_int("os_int_stays0", 1'b0);

        // Periodic, InitVal=2
        wr_tcfg(32'h0B);
        rd("per_load", 12'h042, 32'd8);
        idle(8);
        rd("per_zero", 12'h042, 32'd0);
        chk_int("per_int_before", 1'b0);
        idle(1);
        chk_int("per_int_e9", 1'b1);
        rd("per_reload", 12'h042, 32'd8);
        clr_ti();
        chk_int("per_clr_e10", 1'b0);
        rd("per_dec_e10", 12'h042, 32'd7);
        idle(7);
        chk_int("per_int_e17", 1'b0);
        idle(1);
        chk_int("per_int_e18", 1'b1);
        rd("per_reload2", 12'h042, 32'd8);
        wr_tcfg(32'h0);
        clr_ti();

        // Reprogram mid-count, then freeze
        wr_tcfg(32'h41);
        rd("rp_load64", 12'h042, 32'd64);
        idle(44);
        rd("rp_at20", 12'h042, 32'd20);
        wr_tcfg(32'h09);
        rd("rp_reload8", 12'h042, 32'd8);
        idle(8);
        chk_int("rp_int_before", 1'b0);
        idle(1);
        chk_int("rp_int_expiry", 1'b1);
        clr_ti();
        wr_tcfg(32'h09);
        idle(3);
        rd("rp_at5", 12'h042, 32'd5);
        wr_tcfg(32'h0);
        rd("rp_frozen", 12'h042, 32'd5);
        idle(100);
        rd("rp_frozen100", 12'h042, 32'd5);
        chk_int("rp_no_int", 1'b0);

        // Clear on the expiry edge: set wins
        wr_tcfg(32'h05);
        rd("col_load4", 12'h042, 32'd4);
        idle(4);
        rd("col_zero", 12'h042, 32'd0);
        clr_ti();
        chk_int("col_set_wins", 1'b1);
        rd("col_tval_ones", 12'h042, 32'hFFFF_FFFF);

        // Masked En-only clear keeps InitVal/Periodic and freezes TVAL
        wr_tcfg(32'h0B);
        idle(2);
        rd("msk_at6", 12'h042, 32'd6);
        cyc(1'b1, 12'h041, 32'h1, 32'h0);
        rd("msk_tcfg", 12'h041, 32'h0A);
        rd("msk_tval", 12'h042, 32'd6);
        idle(5);
        rd("msk_tval_held", 12'h042, 32'd6);
        chk_int("msk_int_kept", 1'b1);

        // Reset mid-count with TI set
        wr_tcfg(32'h11);
        idle(9);
        rd("rst_at7", 12'h042, 32'd7);
        chk_int("rst_int_pre", 1'b1);
        rst_cyc();
        chk_int("rst_int", 1'b0);
        rd("rst_tval", 12'h042, 32'hFFFF_FFFF);
        rd("rst_tcfg", 12'h041, 32'h0);
        rd("rst_tid", 12'h040, 32'h0);
        idle(30);
        chk_int("rst_no_expiry", 1'b0);
        rd("rst_tval_held", 12'h042, 32'hFFFF_FFFF);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            int          r;
            int          pick;
            bit          we;
            logic [11:0] num;
            logic [11:0] rnum;
            logic [31:0] mask;
            logic [31:0] data;
            r    = $urandom_range(0, 299);
            pick = $urandom_range(0, 5);
            we   = (r < 36);
            case (pick)
                0:       num = 12'h040;
                1, 5:    num = 12'h041;
                2:       num = 12'h042;
                3:       num = 12'h044;
                default: num = 12'($urandom);
            endcase
            mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            if (num == 12'h041 && $urandom_range(0, 7) != 0) data = $urandom_range(0, 40);
            else data = $urandom;
            if (r == 299) rst_cyc();
            else cyc(we, num, mask, data);
            rnum = 12'h040 + 12'($urandom_range(0, 5));
            bus.csr_num = rnum;
            #1;
            chk("rnd_rdata", bus.csr_rdata, model_rd(rnum));
            chk("rnd_hit", {31'b0, bus.csr_hit}, {31'b0, model_hit(rnum)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_timer.md
Name: csr_timer

Overview:
- Constant-timer CSR block: holds TID, TCFG, TVAL and TICLR, runs the down-counter and produces the timer interrupt.
- Sits beside the CSR file in the WB stage. Shares the same CSR write bus (csr_we/csr_num/csr_wmask/csr_wdata).
- Its timer_int output drives the CSR file's timer_int input, which samples it into ESTAT.IS[11].
- The top level ORs its csr_rdata into the CSR read mux.

Parameters:
- TIMER_W, 32, counter width in bits (8..32). TCFG.InitVal occupies [TIMER_W-1:2].
- TID_RST, 32'h0, reset value of TID.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- csr_we  input  1  CSR write strobe (qualified, one cycle per instruction)
- csr_num  input  12  CSR address for both read and write
- csr_wmask  input  32  per-bit write mask
- csr_wdata  input  32  write data
- csr_rdata  output  32  combinational read data; 0 if csr_num is not owned by this block
- csr_hit  output  1  csr_num is one of TID/TCFG/TVAL/TICLR
- timer_int  output  1  registered interrupt pending (TI)

Behaviour:
- Addresses: TID=0x040, TCFG=0x041, TVAL=0x042, TICLR=0x044.
- Masked write rule: new = (old & ~csr_wmask) | (csr_wdata & csr_wmask).
- Reset:
  - TID=TID_RST, TCFG=0, TVAL=all ones (TIMER_W bits), TI=0, state=IDLE.
  - Outputs after reset: timer_int=0, csr_hit/csr_rdata combinational.
  - Reset mid-count aborts the count and clears TI in the same edge.
- TCFG layout: bit0 En, bit1 Periodic, [TIMER_W-1:2] InitVal. Bits above TIMER_W read 0.
- TVAL is read-only; writes are ignored. Reads are zero-extended to 32 bits.
- TICLR reads 0. Writing with wmask[0]&wdata[0]=1 clears TI; other bits are ignored.
- Writing TID updates TID only; no timer side effect.
- State machine (2-bit register):
  - IDLE: not counting. A TCFG write with new En=1 loads TVAL={InitVal,2'b00} -> COUNT. A TCFG write with En=0 stays IDLE and TVAL is unchanged.
  - COUNT:
    - Each cycle without a TCFG write: if TVAL!=0, TVAL<=TVAL-1.
    - If TVAL==0 (expiry edge): TI<=1. If Periodic=1, TVAL<={InitVal,2'b00} and stay COUNT. Else TVAL<=all ones -> EXPIRED.
  - EXPIRED: TVAL holds all ones, no counting. A TCFG write with En=1 reloads TVAL -> COUNT; with En=0 -> IDLE.
- TCFG write in any state:
  - Takes priority over decrement and expiry in that cycle. TVAL reloads from the newly written InitVal; no expiry is signalled that cycle.
  - New En=0 -> IDLE, TVAL frozen at its current value.
- Latency:
  - TCFG write at edge E0 gives TVAL=4*InitVal after E0. First decrement at E1.
  - Expiry edge is E(4*InitVal+1). timer_int is high from that edge (one register, no combinational path to inputs).
  - InitVal=0 with En=1: TVAL=0 after E0, expiry at E1.
- Simultaneous TICLR clear and expiry on the same edge: set wins, TI=1.
- Simultaneous TICLR clear and TCFG write: both take effect (TI cleared, TVAL reloaded).
- TI stays set until cleared by TICLR or reset. Later expiries while TI=1 leave it 1.
- Arithmetic: TVAL decrements modulo 2^TIMER_W, but never wraps because the decrement is guarded by TVAL!=0.
- csr_we=0 while csr_num addresses this block: no state change. Reads have no side effects.

Test Plan:
- Reset, then read 0x041/0x042/0x044 -> 0x0, 0xFFFFFFFF, 0x0; timer_int=0; csr_hit=1. Read 0x005 -> csr_hit=0, csr_rdata=0.
- One-shot: write TCFG=0x00000011 (InitVal=4, En=1) at E0 -> TVAL=16 after E0, 0 after E16, timer_int=1 after E17, TVAL=0xFFFFFFFF and held thereafter. Then write TICLR=1 (mask 1) -> timer_int=0 next edge, stays 0.
- Periodic: write TCFG=0x0000000B (InitVal=2, Per=1, En=1) -> expiry at E9; TVAL reloads 8 and expires again at E18. Clear TI at E10 -> timer_int re-asserts at E18.
- Reprogram mid-count: TCFG=0x00000041 (InitVal=16), then at TVAL=20 write TCFG=0x00000009 (InitVal=2) -> TVAL=8 next edge and expiry 9 edges later. Write TCFG=0x0 at TVAL=5 -> TVAL frozen at 5, no interrupt for 100 cycles.
- Clear/expiry collision: TICLR write on the exact expiry edge -> timer_int=1. Masked write TCFG with wmask=0x1, wdata=0x0 while counting -> En=0, other fields kept, IDLE.
- Reset mid-count with TI=1 and TVAL=7 -> timer_int=0, TVAL=0xFFFFFFFF, TCFG=0 after the reset edge; no expiry afterwards.
